mux4way16_rr_arbiter: RTL and testbench
=======================================

// Module: mux4way16_rr_arbiter
// PURPOSE
//   Shares a single 16-bit output channel between four requesters (a..d) using
//   round-robin arbitration. Data path is a Mux4Way16 instance steered by the
//   registered grant index, feeding a one-entry output register with a
//   valid/ready handshake. Sits between producer blocks and any single
//   16-bit consumer (ALU operand bus, memory write port).
// PARAMETERS
//   RR_ENABLE   1   1 = round-robin priority; 0 = fixed priority a>b>c>d
// PORTS
//   clk        in   1   single clock, all state updates on rising edge
//   rst_n      in   1   asynchronous, active-low reset
//   req_a..d   in   1   requester has a word pending; holds until its ack
//   in_a..d    in   16  requester data; stable while its req is high
//   ack_a..d   out  1   word accepted at this rising edge (combinational)
//   out        out  16  registered output word
//   out_src    out  2   source of out: 00=a 01=b 10=c 11=d (Mux4Way16 sel code)
//   out_valid  out  1   out/out_src hold a word not yet taken
//   out_ready  in   1   consumer takes word on edge where out_valid&out_ready
// BEHAVIOUR
//   Reset (rst_n=0, any time, async): out=0, out_src=00, out_valid=0,
//     priority pointer ptr=00 (a highest). In-flight word is discarded; acks
//     are 0 while rst_n=0.
//   States: EMPTY (out_valid=0), FULL (out_valid=1).
//   load = ~out_valid | out_ready   (output register can accept this edge).
//   Grant: among asserted req_x, choose first in order ptr, ptr+1, ptr+2,
//     ptr+3 (mod 4); RR_ENABLE=0 forces order a,b,c,d regardless of ptr.
//     gidx = chosen index; Mux4Way16 sel = gidx.
//   ack_x = load & any_req & (gidx==x); at most one ack high per cycle;
//     ack is purely combinational from req_*, out_valid, out_ready, ptr.
//   On rising edge with any ack: out<=in_gidx, out_src<=gidx, out_valid<=1,
//     ptr<=gidx+1 (mod 4, 11 wraps to 00). Latency req->out_valid = 1 cycle
//     when EMPTY.
//   On edge with out_valid&out_ready and no ack: out_valid<=0 (FULL->EMPTY);
//     out/out_src keep last value.
//   FULL & out_ready & req pending: take and reload on same edge (back-to-back,
//     one word per cycle sustained, no bubble).
//   FULL & ~out_ready: no acks; out, out_src, ptr frozen; reqs wait.
//   Requester dropping req without ack: legal, no effect. req held after ack
//     is treated as a new word at next arbitration.
//   Fairness: with all four reqs held continuously and out_ready=1, grants
//     cycle a,b,c,d,a...; a waiting requester is served within 4 acceptances.
// TESTING
//   1 Reset: rst_n=0 mid-FULL (out=0xBEEF) -> out=0, out_valid=0, ptr=00
//     immediately, acks 0; release, req_c=1 in_c=0x1234 -> ack_c, next cycle
//     out=0x1234 out_src=10 out_valid=1.
//   2 All req high, out_ready=1, in_a..d=0x000A,0x000B,0x000C,0x000D ->
//     out sequence A,B,C,D,A on consecutive cycles, out_src 00,01,10,11,00.
//   3 Backpressure: FULL with out=0x00A5, out_ready=0 for 5 cycles, req_b=1 ->
//     no ack_b, out stable 0x00A5; raise out_ready -> ack_b same cycle, out
//     updates next edge with no empty cycle.
//   4 Wrap: last grant d (ptr=00), req_a=req_d=1 -> a granted; next with
//     req_d only -> d granted, ptr=00.
//   5 RR_ENABLE=0, all reqs held -> only a acked every cycle; drop req_a ->
//     b acked.
//   6 Drain: single word, out_ready=1 one cycle, no reqs -> out_valid 1->0,
//     out keeps value, out_src unchanged.

Source files
------------

// File: rtl/mux4way16_rr_arbiter.sv
// Four-requester round-robin arbiter sharing one 16-bit channel through a
// Mux4Way16 and a one-entry valid/ready output register.

module mux4way16 #(
  parameter int VEC_W = 16
) (
  input  logic [3:0][VEC_W-1:0] din,
  input  logic [1:0]            sel,
  output logic [VEC_W-1:0]      dout
);
  assign dout = din[sel];
endmodule

module mux4way16_rr_lane #(
  parameter int LANE = 0
) (
  input  logic       grant_en,
  input  logic       req,
  input  logic [1:0] gidx,
  output logic       ack
);
  assign ack = grant_en & req & (gidx == 2'(LANE));
endmodule

module mux4way16_rr_arbiter #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic        req_b,
  input  logic        req_c,
  input  logic        req_d,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [15:0] in_c,
  input  logic [15:0] in_d,
  output logic        ack_a,
  output logic        ack_b,
  output logic        ack_c,
  output logic        ack_d,
  output logic [15:0] out,
  output logic [1:0]  out_src,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 16;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                              state_q, state_d;
  logic [1:0]                          ptr_q, gidx, idx;
  logic                                found, any_req, load, grant_en;
  logic [NUM_LANES-1:0]                req, ack;
  logic [NUM_LANES-1:0][VEC_W-1:0]     din;
  logic [VEC_W-1:0]                    mux_out, out_q;
  logic [1:0]                          src_q;

  assign req = {req_d, req_c, req_b, req_a};
  assign din = {in_d, in_c, in_b, in_a};

  assign any_req  = |req;
  assign load     = (state_q == EMPTY) | out_ready;
  // rst_n gates the grant so acks stay low for the whole reset window
  assign grant_en = rst_n & load & any_req;

  always_comb begin
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = RR_ENABLE ? (ptr_q + 2'(k)) : 2'(k);
      if (!found && req[idx]) begin
        gidx  = idx;
        found = 1'b1;
      end
    end
  end

  genvar gl;
  generate
    for (gl = 0; gl < NUM_LANES; gl++) begin : g_lane
      mux4way16_rr_lane #(.LANE(gl)) u_lane (
        .grant_en (grant_en),
        .req      (req[gl]),
        .gidx     (gidx),
        .ack      (ack[gl])
      );
    end
  endgenerate

  assign {ack_d, ack_c, ack_b, ack_a} = ack;

  mux4way16 #(.VEC_W(VEC_W)) u_mux (
    .din  (din),
    .sel  (gidx),
    .dout (mux_out)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (grant_en) state_d = FULL;
      FULL:    if (grant_en) state_d = FULL;
               else if (out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      out_q   <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        out_q <= mux_out;
        src_q <= gidx;
        ptr_q <= gidx + 2'd1;
      end
    end
  end

  assign out       = out_q;
  assign out_src   = src_q;
  assign out_valid = (state_q == FULL);
endmodule

// File: tb/tb_mux4way16_rr_arbiter.sv
// Randomized + directed bench: a round-robin and a fixed-priority instance
// share stimulus and are both checked against an in-bench behavioural model.

module tb_mux4way16_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        out_ready = 1'b0;
  logic        req [4];
  logic [15:0] din [4];

  logic [3:0]  ack_rr, ack_fp;
  logic [15:0] out_rr, out_fp;
  logic [1:0]  src_rr, src_fp;
  logic        vld_rr, vld_fp;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // model state: index 0 = round-robin instance, 1 = fixed-priority
  int          m_ptr [2] = '{0, 0};
  logic [15:0] m_out [2] = '{16'h0, 16'h0};
  int          m_src [2] = '{0, 0};
  bit          m_vld [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  mux4way16_rr_arbiter #(.RR_ENABLE(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req_a(req[0]), .req_b(req[1]), .req_c(req[2]), .req_d(req[3]),
    .in_a(din[0]), .in_b(din[1]), .in_c(din[2]), .in_d(din[3]),
    .ack_a(ack_rr[0]), .ack_b(ack_rr[1]), .ack_c(ack_rr[2]), .ack_d(ack_rr[3]),
    .out(out_rr), .out_src(src_rr), .out_valid(vld_rr), .out_ready(out_ready)
  );

  mux4way16_rr_arbiter #(.RR_ENABLE(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req_a(req[0]), .req_b(req[1]), .req_c(req[2]), .req_d(req[3]),
    .in_a(din[0]), .in_b(din[1]), .in_c(din[2]), .in_d(din[3]),
    .ack_a(ack_fp[0]), .ack_b(ack_fp[1]), .ack_c(ack_fp[2]), .ack_d(ack_fp[3]),
    .out(out_fp), .out_src(src_fp), .out_valid(vld_fp), .out_ready(out_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Winner = first pending requester at distance 0..3 past the pointer.
  function automatic int mgrant(input int m);
    for (int d = 0; d < 4; d++) begin
      int who;
      who = (m == 0) ? (m_ptr[m] + d) % 4 : d;
      if (req[who] === 1'b1) return who;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_ptr[m] <= 0; m_out[m] <= 16'h0; m_src[m] <= 0; m_vld[m] <= 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        int g;
        g = mgrant(m);
        if ((!m_vld[m] || out_ready) && g >= 0) begin
          m_out[m] <= din[g];
          m_src[m] <= g;
          m_vld[m] <= 1'b1;
          m_ptr[m] <= (g + 1) % 4;
        end else if (m_vld[m] && out_ready) begin
          m_vld[m] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        int g;
        logic [3:0] exp_ack;
        g = mgrant(m);
        exp_ack = (rst_n && (!m_vld[m] || out_ready) && g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk($sformatf("ack[%0d]", m), (m == 0) ? ack_rr : ack_fp, exp_ack);
        chk($sformatf("valid[%0d]", m), (m == 0) ? vld_rr : vld_fp, m_vld[m]);
        chk($sformatf("src[%0d]", m), (m == 0) ? src_rr : src_fp, m_src[m]);
        chk($sformatf("out[%0d]", m), (m == 0) ? out_rr : out_fp, m_out[m]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bit acked [4];
    for (int i = 0; i < 4; i++) begin req[i] = 1'b0; din[i] = 16'h0; acked[i] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out_rr, 16'h0);
    chk("rst_valid", vld_rr, 1'b0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // fairness sweep; fixed-priority copy keeps picking a
    for (int i = 0; i < 4; i++) begin req[i] = 1'b1; din[i] = 16'h000A + 16'(i); end
    out_ready = 1'b1;
    #1;
    chk("rr_first_ack", ack_rr, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_seq_out", out_rr, 16'h000A + 16'(i % 4));
      chk("rr_seq_src", src_rr, i % 4);
      chk("fp_seq_out", out_fp, 16'h000A);
    end
    req[0] = 1'b0;
    #1;
    chk("fp_drop_a", ack_fp, 4'b0010);
    tick();
    chk("fp_out_b", out_fp, 16'h000B);
    for (int i = 0; i < 4; i++) req[i] = 1'b0;
    tick(); tick();

    // async reset while FULL
    out_ready = 1'b0;
    req[0] = 1'b1; din[0] = 16'hBEEF;
    tick();
    chk("full_beef", out_rr, 16'hBEEF);
    rst_n = 1'b0;
    #1;
    chk("arst_out", out_rr, 16'h0);
    chk("arst_valid", vld_rr, 1'b0);
    chk("arst_ack", ack_rr, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    req[0] = 1'b0; req[2] = 1'b1; din[2] = 16'h1234;
    #1;
    chk("post_rst_ack_c", ack_rr, 4'b0100);
    tick();
    req[2] = 1'b0;
    chk("post_rst_out", out_rr, 16'h1234);
    chk("post_rst_src", src_rr, 2'b10);
    chk("post_rst_valid", vld_rr, 1'b1);

    // backpressure then back-to-back reload
    out_ready = 1'b1;
    req[0] = 1'b1; din[0] = 16'h00A5;
    tick();
    req[0] = 1'b0; out_ready = 1'b0;
    req[1] = 1'b1; din[1] = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_no_ack", ack_rr, 4'b0000);
      chk("bp_out", out_rr, 16'h00A5);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ack", ack_rr, 4'b0010);
    tick();
    req[1] = 1'b0;
    chk("bp_reload_out", out_rr, 16'h5555);
    chk("bp_reload_valid", vld_rr, 1'b1);

    // pointer wrap after d
    req[3] = 1'b1; din[3] = 16'hDDDD;
    #1;
    chk("wrap_d_first", ack_rr, 4'b1000);
    tick();
    din[3] = 16'hD0D0; req[0] = 1'b1; din[0] = 16'h0A0A;
    #1;
    chk("wrap_a_wins", ack_rr, 4'b0001);
    tick();
    chk("wrap_out_a", out_rr, 16'h0A0A);
    req[0] = 1'b0;
    #1;
    chk("wrap_d_next", ack_rr, 4'b1000);
    tick();
    chk("wrap_src_d", src_rr, 2'b11);
    req[0] = 1'b1;
    #1;
    chk("wrap_ptr0", ack_rr, 4'b0001);
    for (int i = 0; i < 4; i++) req[i] = 1'b0;

    // drain single word
    tick();
    chk("drain_valid", vld_rr, 1'b0);
    chk("drain_out", out_rr, 16'hD0D0);
    chk("drain_src", src_rr, 2'b11);
    out_ready = 1'b0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (acked[i] || (req[i] && $urandom_range(15) == 0)) req[i] = 1'b0;
        if (!req[i] && $urandom_range(2) == 0) begin
          req[i] = 1'b1;
          din[i] = 16'($urandom);
        end
      end
      out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(499) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) acked[i] = ack_rr[i];
    end

    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
